// File: rtl/clock_divider_bank.sv
`default_nettype none
// ============================================================================
//  Module   : clock_divider_bank
//  Purpose  : Bank of CHANNELS programmable clock dividers driven from one
//             fast system clock. Each channel produces a 50 % duty divided
//             clock plus a one-cycle tick on every divided-clock rising edge.
//             Divisors (half-periods) are reprogrammed at runtime. A new
//             value is held in a shadow register and takes effect at the
//             channel's next toggle boundary, so the output never glitches.
//             A global sync input re-phases every channel at once.
//  Ports    : inputClock  - system clock, rising-edge logic
//             reset       - synchronous active-high reset
//             cfg_valid   - divisor write strobe (always accepted)
//             cfg_channel - target channel of the write
//             cfg_divisor - new half-period in cycles, 0 stops the channel
//             sync        - single-cycle request to re-phase all channels
//             outputClock - registered divided clocks
//             tick        - one-cycle strobe on each outputClock rise
//             pending     - channel holds a written, not yet applied divisor
//  Revision : 1.0 - initial release
// ============================================================================
module clock_divider_bank #(
    parameter int CHANNELS      = 4,
    parameter int WIDTH         = 16,
    parameter int RESET_DIVISOR = 25000,
    parameter int CH_BITS       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                inputClock,
    input  logic                reset,
    input  logic                cfg_valid,
    input  logic [CH_BITS-1:0]  cfg_channel,
    input  logic [WIDTH-1:0]    cfg_divisor,
    input  logic                sync,
    output logic [CHANNELS-1:0] outputClock,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    localparam logic [WIDTH-1:0] c_reset_div = WIDTH'(RESET_DIVISOR);
    localparam logic [WIDTH-1:0] c_zero      = '0;
    localparam logic [WIDTH-1:0] c_one       = WIDTH'(1);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch

        logic [WIDTH-1:0] r_cnt_q;
        logic [WIDTH-1:0] w_cnt_d;
        logic [WIDTH-1:0] r_act_q;
        logic [WIDTH-1:0] w_act_d;
        logic [WIDTH-1:0] r_shd_q;
        logic [WIDTH-1:0] w_shd_d;
        logic             r_pend_q;
        logic             w_pend_d;
        logic             r_clk_q;
        logic             w_clk_d;
        logic             r_tick_q;
        logic             w_tick_d;

        logic             w_wr;
        logic             w_running;
        logic [WIDTH-1:0] w_act_m1;
        logic             w_bnd;
        logic [WIDTH-1:0] w_next_act;

        // An out-of-range cfg_channel simply matches no channel.
        assign w_wr      = cfg_valid && (cfg_channel == CH_BITS'(gi));
        assign w_running = (r_act_q != c_zero);
        // Decrement only when the divisor is non-zero so it never wraps.
        assign w_act_m1  = w_running ? (r_act_q - c_one) : c_zero;
        assign w_bnd     = w_running && (r_cnt_q == w_act_m1);

        always_comb begin
            w_cnt_d    = r_cnt_q;
            w_act_d    = r_act_q;
            w_shd_d    = r_shd_q;
            w_pend_d   = r_pend_q;
            w_clk_d    = r_clk_q;
            w_tick_d   = 1'b0;
            w_next_act = r_act_q;

            if (sync) begin
                // Re-phase: restart from a low half-period, flushing any
                // pending divisor; a same-cycle write wins over the shadow.
                w_cnt_d = c_zero;
                w_clk_d = 1'b0;
                if (r_pend_q) begin
                    w_act_d  = r_shd_q;
                    w_pend_d = 1'b0;
                end
                if (w_wr) begin
                    w_act_d  = cfg_divisor;
                    w_pend_d = 1'b0;
                end
            end else if (!w_running) begin
                // Stopped: there is no boundary to wait for, so a write
                // loads the divisor directly and counting restarts at 0.
                w_cnt_d = c_zero;
                w_clk_d = 1'b0;
                if (w_wr) begin
                    w_act_d  = cfg_divisor;
                    w_pend_d = 1'b0;
                end
            end else if (!w_bnd) begin
                w_cnt_d = r_cnt_q + c_one;
                if (w_wr) begin
                    w_shd_d  = cfg_divisor;
                    w_pend_d = 1'b1;
                end
            end else begin
                // Toggle boundary: the only point a new divisor may land.
                w_cnt_d    = c_zero;
                w_next_act = r_pend_q ? r_shd_q : r_act_q;
                w_act_d    = w_next_act;
                w_pend_d   = 1'b0;
                if (w_next_act == c_zero) begin
                    w_clk_d = 1'b0;
                end else begin
                    w_clk_d  = ~r_clk_q;
                    w_tick_d = ~r_clk_q;
                end
                if (w_wr) begin
                    if (w_next_act == c_zero) begin
                        // Channel stops this cycle; a shadow would never be
                        // consumed, so the new value starts it up directly.
                        w_act_d = cfg_divisor;
                    end else begin
                        w_shd_d  = cfg_divisor;
                        w_pend_d = 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge inputClock) begin
            if (reset) begin
                r_cnt_q  <= c_zero;
                r_act_q  <= c_reset_div;
                r_shd_q  <= c_reset_div;
                r_pend_q <= 1'b0;
                r_clk_q  <= 1'b0;
                r_tick_q <= 1'b0;
            end else begin
                r_cnt_q  <= w_cnt_d;
                r_act_q  <= w_act_d;
                r_shd_q  <= w_shd_d;
                r_pend_q <= w_pend_d;
                r_clk_q  <= w_clk_d;
                r_tick_q <= w_tick_d;
            end
        end

        assign outputClock[gi] = r_clk_q;
        assign tick[gi]        = r_tick_q;
        assign pending[gi]     = r_pend_q;

    end : g_ch

endmodule : clock_divider_bank
`default_nettype wire

// File: tb/tb_clock_divider_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_divider_bank
//  Purpose  : Self-checking bench for clock_divider_bank (3 channels, 8-bit
//             divisors, reset half-period 4). A time-based model predicts
//             each channel's output from the edge index of its last
//             re-phase point and its divisor; directed literals pin it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clock_divider_bank;

    localparam int CH  = 3;
    localparam int W   = 8;
    localparam int RST = 4;
    localparam int CB  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_valid;
    logic [CB-1:0] cfg_channel;
    logic [W-1:0]  cfg_divisor;
    logic          sync;
    logic [CH-1:0] out_clk;
    logic [CH-1:0] out_tick;
    logic [CH-1:0] out_pend;

    int checks = 0;
    int errors = 0;

    clock_divider_bank #(
        .CHANNELS      (CH),
        .WIDTH         (W),
        .RESET_DIVISOR (RST)
    ) dut (
        .inputClock  (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_channel (cfg_channel),
        .cfg_divisor (cfg_divisor),
        .sync        (sync),
        .outputClock (out_clk),
        .tick        (out_tick),
        .pending     (out_pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: a running channel with divisor d re-phased at edge t0 with
    // level l0 has boundaries at t0 + k*d, and its level at edge t is
    // l0 xor parity((t - t0) / d).
    // ------------------------------------------------------------------
    int       cyc = 0;
    bit       model_ok = 0;
    int       m_d   [CH];
    int       m_shd [CH];
    bit       m_pend[CH];
    int       m_t0  [CH];
    bit       m_l0  [CH];
    logic [CH-1:0] exp_clk, exp_tick, exp_pend;
    bit       m_wr, m_lvl;
    int       m_k;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            model_ok = 1;
            for (int ch = 0; ch < CH; ch++) begin
                m_d[ch] = RST; m_shd[ch] = RST; m_pend[ch] = 0;
                m_t0[ch] = cyc; m_l0[ch] = 0;
                exp_clk[ch] = 0; exp_tick[ch] = 0; exp_pend[ch] = 0;
            end
        end else begin
            for (int ch = 0; ch < CH; ch++) begin
                m_wr = cfg_valid && (int'(cfg_channel) == ch);
                exp_tick[ch] = 0;
                if (sync) begin
                    if (m_pend[ch]) begin m_d[ch] = m_shd[ch]; m_pend[ch] = 0; end
                    if (m_wr) m_d[ch] = int'(cfg_divisor);
                    m_t0[ch] = cyc; m_l0[ch] = 0; exp_clk[ch] = 0;
                end else if (m_d[ch] == 0) begin
                    if (m_wr) m_d[ch] = int'(cfg_divisor);
                    m_t0[ch] = cyc; m_l0[ch] = 0; exp_clk[ch] = 0;
                end else begin
                    m_k   = cyc - m_t0[ch];
                    m_lvl = m_l0[ch] ^ (((m_k / m_d[ch]) % 2) == 1);
                    if (m_k % m_d[ch] == 0) begin
                        if (m_pend[ch]) begin
                            if (m_shd[ch] == 0) m_lvl = 0;
                            m_d[ch] = m_shd[ch]; m_pend[ch] = 0;
                            m_t0[ch] = cyc; m_l0[ch] = m_lvl;
                        end
                        exp_tick[ch] = m_lvl;
                    end
                    exp_clk[ch] = m_lvl;
                    if (m_wr) begin
                        if (m_d[ch] == 0) begin
                            m_d[ch] = int'(cfg_divisor); m_t0[ch] = cyc;
                        end else begin
                            m_shd[ch] = int'(cfg_divisor); m_pend[ch] = 1;
                        end
                    end
                end
                exp_pend[ch] = m_pend[ch];
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_clk",  32'(out_clk),  32'(exp_clk));
            chk("model_tick", 32'(out_tick), 32'(exp_tick));
            chk("model_pend", 32'(out_pend), 32'(exp_pend));
        end
    end

    function automatic bit next_bnd(input int ch);
        return (m_d[ch] != 0) && (((cyc + 1 - m_t0[ch]) % m_d[ch]) == 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write(input int ch, input int d);
        cfg_valid = 1'b1; cfg_channel = CB'(ch); cfg_divisor = W'(d);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_bnd(input int ch, input string nm);
        int n = 0;
        while (!next_bnd(ch) && n < 64) begin step(); n++; end
        if (n >= 64) chk({nm, "_timeout"}, 32'(n), 32'(0));
    endtask

    initial begin
        reset = 1'b1; cfg_valid = 1'b0; cfg_channel = '0; cfg_divisor = '0; sync = 1'b0;
        steps(3);
        chk("rst_clk",  32'(out_clk),  32'h0);
        chk("rst_tick", 32'(out_tick), 32'h0);
        chk("rst_pend", 32'(out_pend), 32'h0);
        reset = 1'b0;

        // First rise 4 edges after the last reset edge, all channels.
        steps(3);
        chk("pre_rise_clk", 32'(out_clk), 32'h0);
        step();
        chk("first_rise_clk",  32'(out_clk),  32'h7);
        chk("first_rise_tick", 32'(out_tick), 32'h7);
        step();
        chk("after_rise_tick", 32'(out_tick), 32'h0);

        // Channel 1: D=2 written at counter 1, applied at the old boundary.
        write(1, 2);
        chk("reprog_pend_a", 32'(out_pend), 32'h2);
        step();
        chk("reprog_pend_b", 32'(out_pend), 32'h2);
        step();
        chk("reprog_pend_clr", 32'(out_pend), 32'h0);
        chk("reprog_fall",     32'(out_clk),  32'h0);
        steps(2);
        chk("reprog_rise_clk",  32'(out_clk),  32'h2);
        chk("reprog_rise_tick", 32'(out_tick), 32'h2);

        // Channel 2: stop at its next boundary, then restart with D=3.
        write(2, 0);
        step();
        chk("stop_clk",  32'(out_clk[2]),  32'h0);
        chk("stop_tick", 32'(out_tick[2]), 32'h0);
        chk("stop_pend", 32'(out_pend[2]), 32'h0);
        steps(5);
        write(2, 3);
        steps(2);
        chk("restart_low", 32'(out_clk[2]), 32'h0);
        step();
        chk("restart_rise_clk",  32'(out_clk[2]),  32'h1);
        chk("restart_rise_tick", 32'(out_tick[2]), 32'h1);

        // Channel 0: 5 then 7 before the boundary, then 6 on the boundary.
        wait_bnd(0, "wb0");
        step();
        write(0, 5);
        write(0, 7);
        chk("lastwins_pend", 32'(out_pend[0]), 32'h1);
        wait_bnd(0, "wb1");
        write(0, 6);
        chk("coincide_pend",   32'(out_pend[0]), 32'h1);
        chk("coincide_period", 32'(m_d[0]),      32'd7);
        begin
            int n = 0;
            while (out_pend[0] && n < 32) begin step(); n++; end
            chk("coincide_apply_cycles", 32'(n), 32'd7);
        end

        // Sync with a same-cycle write to channel 0.
        write(0, 3);
        write(1, 5);
        steps(30);
        sync = 1'b1; cfg_valid = 1'b1; cfg_channel = 2'd0; cfg_divisor = 8'd2;
        step();
        sync = 1'b0; cfg_valid = 1'b0;
        chk("sync_clk",  32'(out_clk),  32'h0);
        chk("sync_tick", 32'(out_tick), 32'h0);
        chk("sync_pend", 32'(out_pend), 32'h0);
        steps(2);
        chk("sync_ch0_rise", 32'(out_clk), 32'h1);
        step();
        chk("sync_ch2_rise", 32'(out_clk), 32'h5);
        step();
        chk("sync_ch0_fall", 32'(out_clk), 32'h4);
        step();
        chk("sync_ch1_rise_clk",  32'(out_clk),  32'h6);
        chk("sync_ch1_rise_tick", 32'(out_tick), 32'h2);

        // Channel 2 at D=1: divided clock at half the system clock.
        write(2, 1);
        steps(12);

        // Out-of-range channel with the largest divisor: no effect.
        write(3, 255);
        chk("oor_pend", 32'(out_pend), 32'h0);
        steps(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_clock_divider_bank
`default_nettype wire
